// File: rtl/wallace_cpa_pipe.sv
// Two-stage carry-propagate adder that finishes the 8x8 Wallace product.
// Stage 1 adds the low six bits of the high part; stage 2 adds the top five plus the ripple carry.
module wallace_cpa_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:5]      x,
    input  logic [15:5]      y,
    input  logic [4:0]       z,
    output logic [15:0]      p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err,
    output logic [CNT_W-1:0] done_cnt
);

    logic             r_v1;
    logic [6:0]       r_lo1;
    logic [4:0]       r_xh1;
    logic [4:0]       r_yh1;
    logic [4:0]       r_z1;

    logic             r_v2;
    logic [4:0]       r_hi2;
    logic [5:0]       r_lo2;
    logic [4:0]       r_z2;

    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    logic             w_ld1;
    logic             w_ld2;
    logic [6:0]       w_lo;
    logic [5:0]       w_hi;

    // Stage 2 frees up whenever it is empty or its product leaves this cycle;
    // stage 1 can then take new data as its content moves forward.
    assign w_ld2 = !r_v2 || out_ready;
    assign w_ld1 = !r_v1 || w_ld2;

    assign w_lo = {1'b0, x[10:5]} + {1'b0, y[10:5]};
    assign w_hi = {1'b0, r_xh1} + {1'b0, r_yh1} + {5'b0, r_lo1[6]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1  <= 1'b0;
            r_lo1 <= '0;
            r_xh1 <= '0;
            r_yh1 <= '0;
            r_z1  <= '0;
        end else if (w_ld1) begin
            r_v1  <= in_valid;
            r_lo1 <= w_lo;
            r_xh1 <= x[15:11];
            r_yh1 <= y[15:11];
            r_z1  <= z;
        end
    end

    // The carry out of bit 15 is only needed for the error flag, so stage 2
    // keeps the truncated five bits of the upper sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2  <= 1'b0;
            r_hi2 <= '0;
            r_lo2 <= '0;
            r_z2  <= '0;
        end else if (w_ld2) begin
            r_v2  <= r_v1;
            r_hi2 <= w_hi[4:0];
            r_lo2 <= r_lo1[5:0];
            r_z2  <= r_z1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_ld2 && r_v1 && w_hi[5]) begin
            r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_v2 && out_ready) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign in_ready  = !rst && w_ld1;
    assign p         = {r_hi2, r_lo2, r_z2};
    assign out_valid = r_v2;
    assign err       = r_err;
    assign done_cnt  = r_cnt;

endmodule

// File: doc/wallace_cpa_pipe.md
WALLACE_CPA_PIPE -- requirements
Module: wallace_cpa_pipe

Purpose: the pipelined carry-propagate stage directly downstream of the 8x8 Wallace compressor. It takes the compressor's sum-high, carry-high and sum-low vectors and produces the final 16-bit product under a valid/ready handshake.

Interface
REQ-001 Parameter CNT_W, default 16: width of the completed-product counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  x/y/z carry a valid compressor result.
REQ-005 in_ready  output  1  block accepts input this cycle.
REQ-006 x  input  [15:5]  compressor sum, high part.
REQ-007 y  input  [15:5]  compressor carry, high part.
REQ-008 z  input  [4:0]  compressor sum, low part (final product bits 4:0).
REQ-009 p  output  [15:0]  final product.
REQ-010 out_valid  output  1  p is valid.
REQ-011 out_ready  input  1  consumer accepts p this cycle.
REQ-012 err  output  1  sticky flag: a carry was generated out of bit 15.
REQ-013 done_cnt  output  [CNT_W-1:0]  number of products delivered.

Function
REQ-014 Arithmetic: p SHALL equal ({x,5'b0} + {y,5'b0} + z) mod 2^16, which is p[4:0]=z and p[15:5]=(x+y)[10:0].
REQ-015 Stage 1 SHALL register lo = x[10:5]+y[10:5] (7 bits, bit 6 = carry c1), x[15:11], y[15:11] and z, with valid flag v1.
REQ-016 Stage 2 SHALL register hi = x[15:11]+y[15:11]+c1 (6 bits, bit 5 = carry-out co), lo[5:0] and z, with valid flag v2.
REQ-017 Output mapping SHALL be p = {hi[4:0], lo[5:0], z} and out_valid = v2.
REQ-018 Transfers: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
REQ-019 Stage 2 SHALL load when !v2 || out_ready.
REQ-020 Stage 1 SHALL load when !v1 || stage-2 load; in_ready SHALL equal that stage-1 load condition, and in_ready SHALL NOT depend on in_valid.
REQ-021 Latency SHALL be 2 cycles from an input transfer to out_valid when there are no stalls; throughput SHALL be one product per cycle with out_ready held high.
REQ-022 On a stall (out_valid=1, out_ready=0): p and v2 SHALL hold, stage 1 SHALL hold if valid, and in_ready SHALL be 0 only when v1=1.
REQ-023 A stage whose upstream has no data while it loads SHALL clear its valid flag. Data registers MAY update while the valid flag is 0.
REQ-024 err SHALL set on the cycle stage 2 loads a valid entry with co=1, and SHALL stay set until rst. p SHALL still follow REQ-017 (truncated).
REQ-025 done_cnt SHALL increment by 1 on each output transfer and wrap from 2^CNT_W-1 to 0.
REQ-026 Inputs are order-preserving: no product SHALL be dropped, duplicated or reordered.

Reset
REQ-027 While rst=1 at a clock edge: v1=0, v2=0, out_valid=0, err=0, done_cnt=0, p=16'h0000.
REQ-028 in_ready SHALL be 0 while rst is asserted and 1 on the first cycle after release.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight products, with no output transfer counted.

Verification
REQ-030 Single product: x=11'h7F0, y=0, z=5'h01, out_ready=1 -> two cycles later out_valid=1, p=16'hFE01, done_cnt=1.
REQ-031 Carry chain: x=y=11'h3F8, z=5'h01 -> p=16'hFE01, err=0. Also x=11'h03F, y=11'h001, z=0 -> p=16'h0800, exercising the c1 ripple into stage 2.
REQ-032 Back-to-back with stall: stream 4 products; hold out_ready=0 for 3 cycles after the first output. Required: p holds, in_ready drops once stage 1 is filled, and all 4 products emerge in order with no gaps after out_ready returns to 1.
REQ-033 Error: x=y=11'h400, z=5'h03 -> p=16'h0003, err=1 and err stays 1 over later clean products until rst.
REQ-034 Wrap and reset: with CNT_W=2, 5 products give done_cnt=1. Asserting rst for 1 cycle with both stages full gives no further out_valid and done_cnt=0.
